// File: rtl/ha_array_accumulator.sv
// Sums the four half-adder-reduced row pairs of the approximate 8x8 multiplier,
// one row per cycle, into a wrapping OUT_W-bit product with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for a bundle; no product pending
// ACCUM | adding row cnt (0..3) into acc, one per cycle
// DONE  | product and tag presented until the consumer takes them
module ha_array_accumulator #(
    parameter int OUT_W = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [8:0]       ha_array_0_t,
    input  logic [6:0]       ha_array_0_b,
    input  logic [8:0]       ha_array_1_t,
    input  logic [6:0]       ha_array_1_b,
    input  logic [8:0]       ha_array_2_t,
    input  logic [6:0]       ha_array_2_b,
    input  logic [8:0]       ha_array_3_t,
    input  logic [6:0]       ha_array_3_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [8:0]       t_r [4];
    logic [6:0]       b_r [4];
    logic [TAG_W-1:0] tag_r;
    logic [OUT_W-1:0] acc;
    logic [1:0]       cnt;

    logic [9:0]       row_sum;
    logic [OUT_W-1:0] row_term;
    logic [OUT_W-1:0] acc_next;

    // Row value fits in 10 bits (max 1019); alignment is 2 bits per row.
    always_comb begin
        row_sum  = {1'b0, t_r[cnt]} + {1'b0, b_r[cnt], 2'b00};
        row_term = OUT_W'(row_sum) << {cnt, 1'b0};
        acc_next = acc + row_term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            tag_r     <= '0;
            product   <= '0;
            out_tag   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                t_r[k] <= '0;
                b_r[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        t_r[0]   <= ha_array_0_t;
                        b_r[0]   <= ha_array_0_b;
                        t_r[1]   <= ha_array_1_t;
                        b_r[1]   <= ha_array_1_b;
                        t_r[2]   <= ha_array_2_t;
                        b_r[2]   <= ha_array_2_b;
                        t_r[3]   <= ha_array_3_t;
                        b_r[3]   <= ha_array_3_b;
                        tag_r    <= in_tag;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state     <= DONE;
                        product   <= acc_next;
                        out_tag   <= tag_r;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low here so accept and emit never share an edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        product   <= '0;
                        out_tag   <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Bench for ha_array_accumulator: directed table, random bundles against a
// bit-weight reference model, stall, mid-accumulate reset and back-to-back flow.
module tb_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [3:0][8:0] t_in;
    logic [3:0][6:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [3:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ha_array_accumulator #(.OUT_W(16), .TAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .ha_array_0_t (t_in[0]),
        .ha_array_0_b (b_in[0]),
        .ha_array_1_t (t_in[1]),
        .ha_array_1_b (b_in[1]),
        .ha_array_2_t (t_in[2]),
        .ha_array_2_b (b_in[2]),
        .ha_array_3_t (t_in[3]),
        .ha_array_3_b (b_in[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .out_tag      (out_tag),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        logic [3:0]      tag;
        logic [15:0]     exp;
    } vec_t;

    vec_t tbl [5];

    // Reference: every set bit contributes its own weight; sum wraps at 2^16.
    function automatic logic [15:0] model(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++)
                if (t[k][i]) s += longint'(1) << (2*k + i);
            for (int i = 0; i < 7; i++)
                if (b[k][i]) s += longint'(1) << (2*k + i + 2);
        end
        return s[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 4; k++) begin
            t_in[k] = 9'($urandom);
            b_in[k] = 7'($urandom);
        end
        in_tag = 4'($urandom);
    endtask

    // Offer one bundle from IDLE with out_ready high; check latency, data and release.
    task automatic send_and_check(input logic [3:0][8:0] t, input logic [3:0][6:0] b,
                                  input logic [3:0] tag, input logic [15:0] exp, input string name);
        int lat;
        t_in = t;
        b_in = b;
        in_tag = tag;
        in_valid = 1'b1;
        out_ready = 1'b1;
        check({name, " ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        randomize_inputs();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " product"}, 32'(product), 32'(exp));
        check({name, " tag"}, 32'(out_tag), 32'(tag));
        tick();
        check({name, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    logic [15:0] hold_p;
    logic [3:0]  hold_tag;
    logic [3:0][8:0] rt;
    logic [3:0][6:0] rb;
    logic [3:0]  rtag;
    logic [19:0] exp_q [$];
    logic [19:0] front;
    bit          was_ready;
    int          last_acc, n_acc, n_out, lat2;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        t_in = '0;
        b_in = '0;
        in_tag = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset in_ready/out_valid/busy", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("reset product", 32'(product), 32'd0);
        check("reset out_tag", 32'(out_tag), 32'd0);

        for (int i = 0; i < 5; i++) tbl[i] = '{t: '0, b: '0, tag: '0, exp: '0};
        tbl[0].t[0] = 9'h001;  tbl[0].tag = 4'h3; tbl[0].exp = 16'h0001;
        tbl[1].b[3] = 7'h40;   tbl[1].tag = 4'h5; tbl[1].exp = 16'h4000;
        tbl[2].t[2] = 9'h100;  tbl[2].tag = 4'h6; tbl[2].exp = 16'h1000;
        for (int k = 0; k < 4; k++) begin
            tbl[3].t[k] = 9'h1FF;
            tbl[3].b[k] = 7'h7F;
        end
        tbl[3].tag = 4'hA; tbl[3].exp = 16'h5257;
        tbl[4].t[1] = 9'h003;  tbl[4].tag = 4'h1; tbl[4].exp = 16'h000C;
        for (int i = 0; i < 5; i++)
            send_and_check(tbl[i].t, tbl[i].b, tbl[i].tag, tbl[i].exp, $sformatf("table%0d", i));

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 4; k++) begin
                rt[k] = 9'($urandom);
                rb[k] = 7'($urandom);
            end
            rtag = 4'($urandom);
            send_and_check(rt, rb, rtag, model(rt, rb), $sformatf("rand%0d", i));
        end

        // Stall in DONE with a competing in_valid.
        out_ready = 1'b0;
        rt = '0; rb = '0;
        rt[0] = 9'h0AB; rb[2] = 7'h15;
        t_in = rt; b_in = rb; in_tag = 4'h9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat2 = 0;
        while (out_valid !== 1'b1 && lat2 < 12) begin
            tick();
            lat2++;
        end
        check("stall latency", 32'(lat2), 32'd4);
        check("stall product", 32'(product), 32'(model(rt, rb)));
        hold_p = product;
        hold_tag = out_tag;
        randomize_inputs();
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("stall hold c%0d", c),
                  {10'd0, product, out_tag, out_valid, in_ready},
                  {10'd0, hold_p, hold_tag, 1'b1, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall handshake", {29'd0, out_valid, in_ready, busy}, 32'b010);
        repeat (3) begin
            tick();
            check("stall no extra output", 32'(out_valid), 32'd0);
        end

        // Reset on the second accumulate cycle drops the bundle.
        randomize_inputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        check("midreset product/tag", {12'd0, product, out_tag}, 32'd0);
        tick();
        check("midreset no output", 32'(out_valid), 32'd0);
        rt = '0; rb = '0; rt[1] = 9'h003;
        send_and_check(rt, rb, 4'h7, 16'h000C, "after reset");

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        randomize_inputs();
        in_valid = 1'b1;
        last_acc = -1; n_acc = 0; n_out = 0;
        for (int cyc = 0; cyc < 80 && n_out < 5; cyc++) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("b2b unexpected output", 32'(out_valid), 32'd0);
                end else begin
                    front = exp_q.pop_front();
                    check($sformatf("b2b product%0d", n_out), 32'(product), 32'(front[19:4]));
                    check($sformatf("b2b tag%0d", n_out), 32'(out_tag), 32'(front[3:0]));
                end
                n_out++;
            end
            was_ready = (in_ready === 1'b1);
            if (was_ready && in_valid) exp_q.push_back({model(t_in, b_in), in_tag});
            tick();
            if (was_ready && in_valid) begin
                if (last_acc >= 0) check("b2b spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                n_acc++;
                if (n_acc == 5) in_valid = 1'b0;
                else randomize_inputs();
            end
        end
        check("b2b outputs", 32'(n_out), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ha_array_accumulator.md
Name: ha_array_accumulator

Overview:
- Downstream stage for the approximate 8x8 unsigned multiplier's half-adder-array partial-product generator.
- Each input bundle carries four row pairs (t, b). Each pair is already half-adder reduced.
- The block aligns the four row pairs and sums them iteratively, one row per cycle, into a 16-bit approximate product.
- Valid/ready handshakes on both sides, so it sits between the combinational generator and a registered result consumer.

Parameters:
- OUT_W, 16: product width; the sum is truncated modulo 2^OUT_W.
- TAG_W, 4: width of the opaque sideband tag. The tag is carried from input to output unchanged.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input bundle valid
- in_ready  output  1  block can accept a bundle
- in_tag  input  TAG_W  sideband tag for the bundle
- ha_array_0_t  input  9  row 0 sum/top bits
- ha_array_0_b  input  7  row 0 carry/bottom bits
- ha_array_1_t  input  9  row 1 sum/top bits
- ha_array_1_b  input  7  row 1 carry/bottom bits
- ha_array_2_t  input  9  row 2 sum/top bits
- ha_array_2_b  input  7  row 2 carry/bottom bits
- ha_array_3_t  input  9  row 3 sum/top bits
- ha_array_3_b  input  7  row 3 carry/bottom bits
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  OUT_W  approximate product
- out_tag  output  TAG_W  tag of the bundle being output
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Bit weights for row k:
  - ha_array_k_t[i] has weight 2^(2k+i).
  - ha_array_k_b[i] has weight 2^(2k+i+2).
- Row value: R_k = (t_k + (b_k << 2)) << 2k.
  - t_k + (b_k << 2) is computed at 10 bits (maximum 1019).
  - R_k is zero-extended to OUT_W before adding.
- Accumulator is OUT_W bits. Any carry out of bit OUT_W-1 is discarded (wraps modulo 2^OUT_W).
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: register all 8 row vectors and in_tag; acc<=0; cnt<=0; go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each cycle: acc<=acc+R_cnt; cnt<=cnt+1.
  - When cnt==3: go to DONE. Exactly 4 accumulate cycles.
- DONE:
  - out_valid=1; product=acc; out_tag=registered tag.
  - On out_ready: go to IDLE.
  - If out_ready is low, hold product and out_tag stable with no change.
- Handshake rules:
  - in_ready depends only on state, never on in_valid.
  - in_ready=0 in DONE even when out_ready=1, so there is no simultaneous accept/emit.
  - Inputs are sampled only on the accept edge. Input changes after acceptance have no effect.
- Latency and throughput:
  - Accept on edge E0 → out_valid high after edge E0+4.
  - With out_ready=1, the output handshake completes at edge E0+5 and the next accept can occur at edge E0+6.
  - Minimum spacing is 6 cycles per bundle.
- Reset (any state, including mid-ACCUM or DONE):
  - Next state IDLE; acc=0, cnt=0, product=0, out_tag=0.
  - out_valid=0, in_ready=1 (after reset deasserts), busy=0.
  - A partially accumulated bundle is dropped; no output is produced for it.
- product and out_tag are registered and read 0 whenever not in DONE after reset. Outside DONE their values are don't-care except immediately after reset.
- busy = (state != IDLE).

Test Plan:
1. Reset, then a bundle with only ha_array_0_t=9'h001, tag=4'h3 → out_valid after 4 accumulate edges; product=16'h0001, out_tag=4'h3.
2. Bundle with only ha_array_3_b[6]=1 → product=16'h4000. Bundle with only ha_array_2_t[8]=1 → product=16'h1000.
3. All t=9'h1FF, all b=7'h7F → sum is 1019×85=86615; product=16'h5257 (wrap, carry discarded).
4. Hold out_ready=0 for 10 cycles in DONE → product/out_tag stable, in_ready=0, a second in_valid is ignored. Raise out_ready → one handshake; in_ready=1 on the next cycle.
5. Assert rst on the 2nd ACCUM cycle → next cycle IDLE: out_valid=0, in_ready=1, busy=0. A fresh bundle (ha_array_1_t=9'h003, rest 0) then yields product=16'h000C.
6. Back-to-back bundles with in_valid held high and out_ready=1 → accepts exactly 6 cycles apart; products and tags emerge in order.
